// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - Memory-stage request/response bus between the datapath and dmem_responder
interface dmem_responder_if;
   logic        mem_read;
   logic        mem_write;
   logic [63:0] addr;
   logic [63:0] write_data;
   logic [63:0] read_data;
   logic        busy;
   logic        done;
   logic        fault;

   modport master (
      output mem_read, mem_write, addr, write_data,
      input  read_data, busy, done, fault
   );

   modport slave (
      input  mem_read, mem_write, addr, write_data,
      output read_data, busy, done, fault
   );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - Single-request doubleword data memory with modelled access latency
// Optional misaligned-address rejection is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 64,
   parameter int LATENCY    = 2
) (
   input  logic            clk,
   input  logic            reset,
   dmem_responder_if.slave bus
);
   localparam int         DEPTH        = 1 << ADDR_WIDTH;
   localparam logic [3:0] CNT_LOAD     = 4'(LATENCY - 1);
   localparam bit         SINGLE_CYCLE = (LATENCY == 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                state, state_next;
   logic [3:0]            cnt, cnt_next;

   logic [ADDR_WIDTH-1:0] cap_idx;
   logic [DATA_WIDTH-1:0] cap_data;
   logic                  cap_write;
   logic                  cap_fault;

   logic                  req_valid;
   logic                  req_fault;
   logic                  req_misaligned;
   logic [ADDR_WIDTH-1:0] req_idx;
   logic                  capture;

   logic [ADDR_WIDTH-1:0] acc_idx;
   logic [DATA_WIDTH-1:0] acc_data;
   logic                  acc_write;
   logic                  acc_fault;

   logic                  enter_resp;
   logic                  mem_we;
   logic                  mem_re;
   logic                  busy_next;
   logic                  done_next;
   logic                  fault_next;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  unused_addr_bits;
   assign unused_addr_bits = ^{bus.addr[63:ADDR_WIDTH+3], bus.addr[2:0]};

   assign req_valid = bus.mem_read | bus.mem_write;
   assign req_idx   = bus.addr[ADDR_WIDTH+2:3];

`ifdef DMEM_ALIGN_CHECK_EN
   assign req_misaligned = (bus.addr[2:0] != 3'b000);
`else
   assign req_misaligned = 1'b0;
`endif

   // Conflicting read+write and misaligned requests still run the full latency, flagged as faults.
   assign req_fault = (bus.mem_read & bus.mem_write) | req_misaligned;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         bus.busy  <= 1'b0;
         bus.done  <= 1'b0;
         bus.fault <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         bus.busy  <= busy_next;
         bus.done  <= done_next;
         bus.fault <= fault_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cap_write <= 1'b0;
         cap_fault <= 1'b0;
      end else if (capture) begin
         cap_write <= bus.mem_write;
         cap_fault <= req_fault;
      end
   end

   always_ff @(posedge clk) begin
      if (capture) begin
         cap_idx  <= req_idx;
         cap_data <= bus.write_data;
      end
   end

   // With LATENCY=1 the access happens on the accept edge, so it uses the live request.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      capture    = 1'b0;
      acc_idx    = cap_idx;
      acc_data   = cap_data;
      acc_write  = cap_write;
      acc_fault  = cap_fault;
      case (state)
         IDLE: begin
            if (req_valid) begin
               capture  = 1'b1;
               cnt_next = CNT_LOAD;
               if (SINGLE_CYCLE) begin
                  state_next = RESP;
                  acc_idx    = req_idx;
                  acc_data   = bus.write_data;
                  acc_write  = bus.mem_write;
                  acc_fault  = req_fault;
               end else begin
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_next = cnt - 4'd1;
            if (cnt <= 4'd1) begin
               state_next = RESP;
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_comb begin
      enter_resp = (state_next == RESP) && (state != RESP);
      mem_we     = enter_resp & acc_write & ~acc_fault & ~reset;
      mem_re     = enter_resp & ~acc_write & ~acc_fault & ~reset;
      busy_next  = (state_next == WAIT);
      done_next  = enter_resp;
      fault_next = enter_resp & acc_fault;
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[acc_idx] <= acc_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.read_data <= 64'd0;
      end else if (mem_re) begin
         bus.read_data <= mem[acc_idx];
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - Directed self-checking bench for dmem_responder
// Second instance runs with LATENCY=3 for back-to-back request behaviour.
module tb_dmem_responder;
   logic        clk = 1'b0;
   logic        reset;
   logic        reset3;
   int          checks = 0;
   int          errors = 0;
   logic [63:0] last_rd;
   logic [7:0]  exp_busy3;
   logic [7:0]  exp_done3;

   dmem_responder_if bus();
   dmem_responder_if bus3();

   dmem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(64), .LATENCY(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   dmem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(64), .LATENCY(3)) dut3 (
      .clk   (clk),
      .reset (reset3),
      .bus   (bus3)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input string tag, input logic rd, input logic wr,
                         input logic [63:0] a, input logic [63:0] d,
                         input logic exp_fault, input logic [63:0] exp_rd);
      bus.mem_read   = rd;
      bus.mem_write  = wr;
      bus.addr       = a;
      bus.write_data = d;
      step();
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      check({tag, ".busy_wait"}, 64'(bus.busy), 64'd1);
      check({tag, ".done_wait"}, 64'(bus.done), 64'd0);
      step();
      check({tag, ".done"}, 64'(bus.done), 64'd1);
      check({tag, ".busy_done"}, 64'(bus.busy), 64'd0);
      check({tag, ".fault"}, 64'(bus.fault), 64'(exp_fault));
      check({tag, ".read_data"}, bus.read_data, exp_rd);
      step();
      check({tag, ".done_after"}, 64'(bus.done), 64'd0);
      check({tag, ".fault_after"}, 64'(bus.fault), 64'd0);
   endtask

   initial begin
      reset           = 1'b1;
      reset3          = 1'b1;
      bus.mem_read    = 1'b0;
      bus.mem_write   = 1'b0;
      bus.addr        = 64'd0;
      bus.write_data  = 64'd0;
      bus3.mem_read   = 1'b0;
      bus3.mem_write  = 1'b0;
      bus3.addr       = 64'd0;
      bus3.write_data = 64'd0;
      repeat (3) step();
      check("rst.read_data", bus.read_data, 64'd0);
      check("rst.busy", 64'(bus.busy), 64'd0);
      check("rst.done", 64'(bus.done), 64'd0);
      check("rst.fault", 64'(bus.fault), 64'd0);
      reset  = 1'b0;
      reset3 = 1'b0;
      step();

      do_req("rt_st", 1'b0, 1'b1, 64'h40, 64'hDEADBEEF_CAFEF00D, 1'b0, 64'h0);
      do_req("rt_ld", 1'b1, 1'b0, 64'h40, 64'h0, 1'b0, 64'hDEADBEEF_CAFEF00D);

      do_req("wrap_st", 1'b0, 1'b1, 64'h0, 64'h1, 1'b0, 64'hDEADBEEF_CAFEF00D);
      do_req("wrap_ld", 1'b1, 1'b0, 64'h2000, 64'h0, 1'b0, 64'h1);

`ifdef DMEM_ALIGN_CHECK_EN
      do_req("align_ld", 1'b1, 1'b0, 64'h44, 64'h0, 1'b1, 64'h1);
      last_rd = 64'h1;
`else
      do_req("align_ld", 1'b1, 1'b0, 64'h44, 64'h0, 1'b0, 64'hDEADBEEF_CAFEF00D);
      last_rd = 64'hDEADBEEF_CAFEF00D;
`endif

      do_req("both_pre", 1'b0, 1'b1, 64'h10, 64'hAAAA, 1'b0, last_rd);
      do_req("both_req", 1'b1, 1'b1, 64'h10, 64'hBBBB, 1'b1, last_rd);
      do_req("both_ld", 1'b1, 1'b0, 64'h10, 64'h0, 1'b0, 64'hAAAA);

      do_req("rst_pre", 1'b0, 1'b1, 64'h18, 64'h1111, 1'b0, 64'hAAAA);
      bus.mem_write  = 1'b1;
      bus.addr       = 64'h18;
      bus.write_data = 64'h55;
      step();
      bus.mem_write = 1'b0;
      reset         = 1'b1;
      step();
      check("rst_mid.read_data", bus.read_data, 64'd0);
      check("rst_mid.busy", 64'(bus.busy), 64'd0);
      check("rst_mid.done", 64'(bus.done), 64'd0);
      check("rst_mid.fault", 64'(bus.fault), 64'd0);
      reset = 1'b0;
      step();
      check("rst_mid.done_idle", 64'(bus.done), 64'd0);
      do_req("rst_ld", 1'b1, 1'b0, 64'h18, 64'h0, 1'b0, 64'h1111);

      // Request held for six sampling edges: accepted, ignored while busy/done, accepted again.
      exp_busy3        = 8'b0011_0011;
      exp_done3        = 8'b0100_0100;
      bus3.mem_write   = 1'b1;
      bus3.addr        = 64'h8;
      bus3.write_data  = 64'h77;
      for (int i = 0; i < 8; i++) begin
         step();
         if (i == 5) bus3.mem_write = 1'b0;
         check($sformatf("hold.busy%0d", i), 64'(bus3.busy), 64'(exp_busy3[i]));
         check($sformatf("hold.done%0d", i), 64'(bus3.done), 64'(exp_done3[i]));
      end
      bus3.mem_read = 1'b1;
      step();
      bus3.mem_read = 1'b0;
      check("l3_ld.busy1", 64'(bus3.busy), 64'd1);
      step();
      check("l3_ld.busy2", 64'(bus3.busy), 64'd1);
      check("l3_ld.done_early", 64'(bus3.done), 64'd0);
      step();
      check("l3_ld.done", 64'(bus3.done), 64'd1);
      check("l3_ld.fault", 64'(bus3.fault), 64'd0);
      check("l3_ld.read_data", bus3.read_data, 64'h77);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
